// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop, lap freeze, clear, and a
// prescaler that issues one count tick every DIV clock cycles.
module stopwatch_ctrl #(
  parameter int unsigned DIV = 1000000,
  parameter int unsigned PW  = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_ss,
  input  logic btn_lap,
  input  logic btn_clr,
  input  logic at_max,
  output logic cnt_en,
  output logic cnt_clr,
  output logic disp_hold,
  output logic running,
  output logic full
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_LAP   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_FULL  = 3'd4;

  localparam logic [PW-1:0] LP_TOP  = PW'(DIV - 1);
  localparam logic [PW-1:0] LP_ZERO = '0;
  localparam logic [PW-1:0] LP_ONE  = PW'(1);

  logic [2:0]    r_state;
  logic [PW-1:0] r_pre;

  logic [2:0]    w_nxt_state;
  logic [PW-1:0] w_nxt_pre;
  logic          w_tick;
  logic          w_clr;
  logic          w_wrap;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pre   = r_pre;
    w_tick      = 1'b0;
    w_clr       = 1'b0;
    w_wrap      = (r_pre == LP_TOP);
    case (r_state)
      S_IDLE: begin
        w_nxt_pre = LP_ZERO;
        if (btn_clr) begin
          w_clr = 1'b1;
        end else if (btn_ss) begin
          w_nxt_state = S_RUN;
        end
      end
      S_RUN, S_LAP: begin
        // A wrap swallows any same-cycle start/stop or lap press.
        if (w_wrap) begin
          w_nxt_pre = LP_ZERO;
          if (at_max) begin
            w_nxt_state = S_FULL;
          end else begin
            w_tick = 1'b1;
          end
        end else begin
          w_nxt_pre = r_pre + LP_ONE;
          if (btn_ss) begin
            w_nxt_state = S_PAUSE;
          end else if (btn_lap) begin
            w_nxt_state = (r_state == S_RUN) ? S_LAP : S_RUN;
          end
        end
      end
      S_PAUSE: begin
        if (btn_clr) begin
          w_nxt_state = S_IDLE;
          w_nxt_pre   = LP_ZERO;
          w_clr       = 1'b1;
        end else if (btn_ss) begin
          w_nxt_state = S_RUN;
        end
      end
      S_FULL: begin
        w_nxt_pre = LP_ZERO;
        if (btn_clr) begin
          w_nxt_state = S_IDLE;
          w_clr       = 1'b1;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_pre   = LP_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pre     <= LP_ZERO;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b1;
      disp_hold <= 1'b0;
      running   <= 1'b0;
      full      <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_pre     <= w_nxt_pre;
      cnt_en    <= w_tick;
      cnt_clr   <= w_clr;
      disp_hold <= (w_nxt_state == S_LAP);
      running   <= (w_nxt_state == S_RUN) ||
                   (w_nxt_state == S_LAP);
      full      <= (w_nxt_state == S_FULL);
    end
  end

endmodule
